// File: rtl/led_servo_driver.sv
// LED mode driver (off/on/blink/PWM) plus 50 Hz hobby-servo pulse generator.
// Define LED_GAMMA_EN to apply a square-law gamma to the PWM duty.
module led_servo_driver #(
  parameter int CLK_HZ = 25_000_000,
  parameter int N_LED  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2*N_LED-1:0]   led_mode,
  input  logic [8*N_LED-1:0]   led_duty,
  input  logic [15:0]          blink_half_ms,
  input  logic [7:0]           servo_pos,
  input  logic                 servo_en,
  output logic [N_LED-1:0]     led,
  output logic                 servo_pin,
  output logic                 frame_start
);

  localparam int PRESC = CLK_HZ / 1_000_000;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;

  generate
    if (PRESC < 2 || (CLK_HZ % 1_000_000) != 0) begin : g_bad_clk
      $error("CLK_HZ must be an integer multiple of 1 MHz and at least 2 MHz");
    end
    if (N_LED < 1 || N_LED > 16) begin : g_bad_nled
      $error("N_LED must be in 1..16");
    end
  endgenerate

  logic [PW-1:0]    r_presc;
  logic [9:0]       r_us_cnt;
  logic [14:0]      r_frame_us;
  logic [15:0]      r_ms_cnt;
  logic             r_blink_ph;
  logic [7:0]       r_pos_l;
  logic             r_en_l;
  logic [7:0]       r_pwm_cnt;

  logic             w_us_tick;
  logic             w_ms_tick;
  logic             w_frame_wrap;
  logic             w_frame_start;
  logic [7:0]       w_pos_clamped;
  logic [7:0]       w_pos_next;
  logic             w_en_next;
  logic [10:0]      w_pulse_us;
  logic             w_servo_next;
  logic [15:0]      w_half_eff;
  logic             w_blink_hit;
  logic             w_blink_ph_next;
  logic [N_LED-1:0] w_led_next;

  assign w_us_tick     = (r_presc == PW'(PRESC - 1));
  assign w_ms_tick     = w_us_tick && (r_us_cnt == 10'd999);
  assign w_frame_wrap  = w_us_tick && (r_frame_us == 15'd19999);
  assign w_frame_start = (r_frame_us == 15'd0) && (r_presc == '0);

  // Position and enable are taken in the frame-start cycle itself so the
  // first high cycle of the pulse already uses the freshly latched values.
  assign w_pos_clamped = (servo_pos > 8'd250) ? 8'd250 : servo_pos;
  assign w_pos_next    = w_frame_start ? w_pos_clamped : r_pos_l;
  assign w_en_next     = w_frame_start ? servo_en : r_en_l;
  assign w_pulse_us    = 11'd1000 + {1'b0, w_pos_next, 2'b00};
  assign w_servo_next  = w_en_next && (r_frame_us < {4'd0, w_pulse_us});

  assign w_half_eff      = (blink_half_ms == 16'd0) ? 16'd1 : blink_half_ms;
  assign w_blink_hit     = w_ms_tick && (r_ms_cnt >= (w_half_eff - 16'd1));
  assign w_blink_ph_next = r_blink_ph ^ w_blink_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_LED; gi++) begin : g_ch
      logic [7:0] r_duty_l;
      logic [7:0] w_duty_cur;
      logic [7:0] w_duty_eff;
      logic [1:0] w_mode;

      assign w_mode     = led_mode[2*gi +: 2];
      // At the wrap the incoming duty is used directly, so every 256-cycle
      // period compares against one duty value from its very first cycle.
      assign w_duty_cur = (r_pwm_cnt == 8'd0) ? led_duty[8*gi +: 8] : r_duty_l;

`ifdef LED_GAMMA_EN
      assign w_duty_eff = 8'(({8'd0, w_duty_cur} * {8'd0, w_duty_cur}) >> 8);
`else
      assign w_duty_eff = w_duty_cur;
`endif

      assign w_led_next[gi] = (w_mode == 2'b00) ? 1'b0 :
                              (w_mode == 2'b01) ? 1'b1 :
                              (w_mode == 2'b10) ? w_blink_ph_next :
                                                  (r_pwm_cnt < w_duty_eff);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_duty_l <= 8'd0;
        end else if (r_pwm_cnt == 8'd0) begin
          r_duty_l <= led_duty[8*gi +: 8];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc     <= '0;
      r_us_cnt    <= 10'd0;
      r_frame_us  <= 15'd0;
      r_ms_cnt    <= 16'd0;
      r_blink_ph  <= 1'b0;
      r_pos_l     <= 8'd0;
      r_en_l      <= 1'b0;
      r_pwm_cnt   <= 8'd0;
      led         <= '0;
      servo_pin   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_presc <= w_us_tick ? '0 : r_presc + PW'(1);
      if (w_us_tick) begin
        r_us_cnt   <= (r_us_cnt == 10'd999) ? 10'd0 : r_us_cnt + 10'd1;
        r_frame_us <= w_frame_wrap ? 15'd0 : r_frame_us + 15'd1;
      end
      if (w_ms_tick) begin
        r_ms_cnt <= w_blink_hit ? 16'd0 : r_ms_cnt + 16'd1;
      end
      r_blink_ph  <= w_blink_ph_next;
      r_pos_l     <= w_pos_next;
      r_en_l      <= w_en_next;
      r_pwm_cnt   <= r_pwm_cnt + 8'd1;
      led         <= w_led_next;
      servo_pin   <= w_servo_next;
      frame_start <= w_frame_start;
    end
  end

endmodule

// File: tb/tb_led_servo_driver.sv
// Directed bench for led_servo_driver at 2 MHz (2 cycles per us) so whole
// servo frames fit in a short run; pulse widths are scoreboarded.
module tb_led_servo_driver;

  localparam int CLK_HZ = 2_000_000;
  localparam int PRESC  = 2;
  localparam int N_LED  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       led_mode = '0;
  logic [15:0]      led_duty = '0;
  logic [15:0]      blink_half_ms = '0;
  logic [7:0]       servo_pos = '0;
  logic             servo_en = 1'b0;
  logic [N_LED-1:0] led;
  logic             servo_pin;
  logic             frame_start;

  led_servo_driver #(.CLK_HZ(CLK_HZ), .N_LED(N_LED)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .led_mode      (led_mode),
    .led_duty      (led_duty),
    .blink_half_ms (blink_half_ms),
    .servo_pos     (servo_pos),
    .servo_en      (servo_en),
    .led           (led),
    .servo_pin     (servo_pin),
    .frame_start   (frame_start)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   exp_q[$];
  int   cyc, hi_len, hi_total, last_fs, fs_count, last_tog, exp_tog, win_n;
  int   win_hi  [N_LED];
  int   exp_duty[N_LED];
  bit   chk_pwm [N_LED];
  bit   chk_blink;
  logic prev_pin, prev_led1;

  function automatic int duty_model(int d);
`ifdef LED_GAMMA_EN
    return (d * d) >> 8;
`else
    return d;
`endif
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic start_run();
    cyc = 0; hi_len = 0; hi_total = 0; last_fs = -1; fs_count = 0;
    last_tog = 0; win_n = 0; prev_pin = 1'b0; prev_led1 = 1'b0;
    for (int c = 0; c < N_LED; c++) win_hi[c] = 0;
  endtask

  // Advance n cycles, sampling 1 time unit after each rising edge.
  task automatic run(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (servo_pin) begin hi_len++; hi_total++; end
      if (prev_pin && !servo_pin) begin
        if (exp_q.size() == 0) begin
          check("pulse_unexpected", hi_len, 0);
        end else begin
          int e;
          e = exp_q.pop_front();
          $display("servo pulse ended at cycle %0d: width %0d, expected %0d", cyc, hi_len, e);
          check("pulse_width", hi_len, e);
        end
        hi_len = 0;
      end
      prev_pin = servo_pin;
      if (frame_start) begin
        if (last_fs < 0) check("first_frame_start", cyc, 1);
        else             check("frame_period", cyc - last_fs, 20000 * PRESC);
        last_fs = cyc;
        fs_count++;
      end
      if (chk_blink && (led[1] !== prev_led1)) begin
        check("blink_interval", cyc - last_tog, exp_tog);
        last_tog = cyc;
      end
      prev_led1 = led[1];
      for (int c = 0; c < N_LED; c++) if (led[c] === 1'b1) win_hi[c]++;
      win_n++;
      if (win_n == 256) begin
        for (int c = 0; c < N_LED; c++) begin
          if (chk_pwm[c]) check($sformatf("pwm_ch%0d", c), win_hi[c], exp_duty[c]);
          win_hi[c] = 0;
        end
        win_n = 0;
      end
    end
  endtask

  initial begin
    chk_blink = 1'b0;
    exp_tog   = 0;
    for (int c = 0; c < N_LED; c++) begin chk_pwm[c] = 1'b0; exp_duty[c] = 0; end

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("reset_led", led, 0);
    check("reset_servo_pin", servo_pin, 0);
    check("reset_frame_start", frame_start, 0);

    // Run A: pos 0, changed to 255 mid-pulse; ch0 PWM 64, ch1 blink 2 ms
    led_mode = 4'b1011; led_duty = {8'd0, 8'd64}; blink_half_ms = 16'd2;
    servo_pos = 8'd0; servo_en = 1'b1;
    chk_pwm[0] = 1'b1; exp_duty[0] = duty_model(64); chk_pwm[1] = 1'b0;
    chk_blink = 1'b1; exp_tog = 2 * 1000 * PRESC;
    exp_q.push_back(1000 * PRESC);
    rst_n = 1'b1; start_run();
    run(1000);
    servo_pos = 8'd255;
    exp_q.push_back(2000 * PRESC);
    run(43100);
    check("runA_pulses_pending", exp_q.size(), 0);
    check("runA_frame_starts", fs_count, 2);

    // Run B: pos 125, ch0 on, ch1 blink with half period 0 (= 1 ms)
    rst_n = 1'b0; repeat (3) @(posedge clk); #1;
    led_mode = 4'b1001; blink_half_ms = 16'd0; servo_pos = 8'd125; servo_en = 1'b1;
    chk_pwm[0] = 1'b0; chk_blink = 1'b1; exp_tog = 1000 * PRESC;
    exp_q.push_back(1500 * PRESC);
    rst_n = 1'b1; start_run();
    run(5000);
    check("mode_on", led[0], 1);
    led_mode = 4'b1000;
    run(1);
    check("mode_off_latency", led[0], 0);
    check("runB_pulses_pending", exp_q.size(), 0);

    // Run C: servo disabled; ch0 PWM duty 0, ch1 PWM duty 10
    rst_n = 1'b0; repeat (3) @(posedge clk); #1;
    led_mode = 4'b1111; led_duty = {8'd10, 8'd0}; servo_pos = 8'd100; servo_en = 1'b0;
    chk_blink = 1'b0;
    chk_pwm[0] = 1'b1; exp_duty[0] = duty_model(0);
    chk_pwm[1] = 1'b1; exp_duty[1] = duty_model(10);
    rst_n = 1'b1; start_run();
    run(5000);
    check("disabled_no_pulse", hi_total, 0);
    check("disabled_frame_start", fs_count, 1);

    // Run D: reset 1000 cycles into a pulse, then a fresh frame at pos 250
    rst_n = 1'b0; repeat (3) @(posedge clk); #1;
    led_duty = {8'd128, 8'd255}; servo_pos = 8'd200; servo_en = 1'b1;
    exp_duty[0] = duty_model(255); exp_duty[1] = duty_model(128);
    rst_n = 1'b1; start_run();
    run(1000);
    check("pulse_in_progress", servo_pin, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset_servo_pin", servo_pin, 0);
    check("midreset_frame_start", frame_start, 0);
    check("midreset_led", led, 0);
    repeat (3) @(posedge clk); #1;
    servo_pos = 8'd250;
    exp_q.push_back(2000 * PRESC);
    rst_n = 1'b1; start_run();
    run(4500);
    check("runD_pulses_pending", exp_q.size(), 0);
    check("runD_frame_starts", fs_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_servo_driver.md
# led_servo_driver

Parametrised board-level output driver running from the 25 MHz system clock. It drives N_LED LED outputs, each with its own mode: off, on, blink, or 8-bit PWM dimming. It also drives one hobby-servo pin with a standard 50 Hz frame and a glitch-free 1000–2000 µs pulse. It replaces the free-running fixed-period toggle used for early bring-up and sits directly at the top level between control logic and the LED/servo pins.

## Interface

Parameters:
- `CLK_HZ`, 25_000_000: input clock frequency. `CLK_HZ/1_000_000` must be an integer ≥ 2; otherwise elaboration fails.
- `N_LED`, 2: number of LED channels, 1..16.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset; synchronous, active-low.
- `led_mode`  in  2*N_LED: per-channel mode, channel i in bits [2i+1:2i]. 00 off, 01 on, 10 blink, 11 PWM.
- `led_duty`  in  8*N_LED: per-channel PWM duty, channel i in bits [8i+7:8i].
- `blink_half_ms`  in  16: blink half-period in ms, shared by all channels. 0 is treated as 1.
- `servo_pos`  in  8: servo position. Values 0..250 are valid; values above 250 are clamped to 250.
- `servo_en`  in  1: enables the servo pulse.
- `led`  out  N_LED: LED drive, active-high.
- `servo_pin`  out  1: servo PWM output.
- `frame_start`  out  1: one-cycle pulse at the start of each 20 ms servo frame.

## Operation

- Prescaler: `PRESC = CLK_HZ/1_000_000`. A µs tick occurs every PRESC cycles. A ms tick occurs every 1000 µs ticks.
- Servo frame counter: counts µs ticks from 0 to 19999, then wraps to 0.
- Frame start is the cycle where the frame counter is 0 and the prescaler is 0. In that cycle:
  - `frame_start` is 1.
  - `servo_pos` is clamped and latched into `pos_l`.
  - `servo_en` is latched into `en_l`.
- `servo_pin` = `en_l` AND (frame_us < 1000 + 4*`pos_l`).
  - Pulse width ranges from 1000 µs (pos 0) to 2000 µs (pos 250), in 4 µs steps.
  - Input changes mid-frame never affect the current pulse.
- `frame_start` pulses every frame regardless of `servo_en`.
- Blink:
  - A ms counter increments on each ms tick.
  - When count ≥ max(`blink_half_ms`,1)−1 on a ms tick, the counter clears and the shared `blink_ph` toggles.
  - Shrinking `blink_half_ms` below the current count causes a toggle on the next ms tick.
- PWM:
  - An 8-bit counter runs at clk rate and wraps every 256 cycles.
  - The per-channel duty is latched when the counter is 0.
  - `led[i]` = (`pwm_cnt` < `duty_eff[i]`). Duty 0 means always off; duty 255 means 255 high cycles out of 256.
- Mode mux per channel: off → 0, on → 1, blink → `blink_ph`, PWM → PWM compare.
- Width rules:
  - 1000 + 4*pos fits in 11 bits.
  - Frame counter is 15 bits.
  - ms counter is 16 bits.
  - Duty product for gamma is 16 bits.

## Timing

- All outputs are registered.
- Reset values:
  - `led` = 0, `servo_pin` = 0, `frame_start` = 0.
  - All counters = 0, `blink_ph` = 0, `pos_l` = 0, `en_l` = 0, latched duties = 0.
- The first `frame_start` (with a simultaneous `servo_pin` rise when `servo_en` = 1) is asserted one cycle after the first rising edge with `rst_n` = 1.
- `led` responds to an `led_mode` change with 1-cycle latency (registered mux). `led_duty` changes take effect at the next PWM wrap.
- Servo pulse: high for exactly (1000+4*pos_l)*PRESC cycles. Frame period is exactly 20000*PRESC cycles.
- Reset mid-operation: all outputs are 0 the cycle after `rst_n` is sampled low. Any in-progress pulse is truncated, and a fresh frame starts after release.
- Simultaneous events: when a ms tick and a frame wrap coincide, both are processed in the same cycle. They are independent.

## Configuration

- `LED_GAMMA_EN` defined: `duty_eff` = (duty*duty)>>8, approximating perceptual gamma 2.
  - duty 255 → 254.
  - duty 1..15 → 0.
- Not defined: `duty_eff` = duty (linear).

## Test plan

- Reset: hold `rst_n` = 0 for 5 cycles → all outputs 0. Release with `servo_pos` = 125 and `servo_en` = 1 → `frame_start` pulse, `servo_pin` high for 37,500 cycles, next `frame_start` 500,000 cycles later.
- Clamp and range: `servo_pos` = 255 → pulse of 50,000 cycles. `servo_pos` = 0 → 25,000 cycles. `servo_en` = 0 → no pulse, but `frame_start` continues.
- Mid-pulse change: `servo_pos` changes from 0 to 250 at cycle 10,000 of a pulse → current pulse is 25,000 cycles, next pulse is 50,000 cycles.
- Blink: `led_mode` = 10 with `blink_half_ms` = 2 → `led` toggles every 50,000 cycles, first rising 50,000 cycles after reset. `blink_half_ms` = 0 → toggles every 25,000 cycles.
- PWM: mode 11, duty 64 → 64 high cycles per 256. Duty 0 → constant 0. Duty 255 → 255/256.
  - With `LED_GAMMA_EN`: duty 128 → 64 high cycles; duty 10 → constant 0.
- Reset mid-pulse: assert `rst_n` low 1,000 cycles into a servo pulse → `servo_pin` is 0 the next cycle, and counters restart on release.
